mem_responder: RTL and testbench

- Synthesizable backing-memory responder for the 128-bit cache-to-memory interface; it is the target end of the cache's mem_req/mem_resp port.
- Accepts read and byte-masked write requests and returns read data in order, after a fixed LATENCY.
- Used as the main-memory stand-in for cache and processor benches, and as an FPGA block-RAM memory.

---
 rtl/mem_responder.sv | 117 +++++++++++
 tb/tb_mem_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Backing-memory responder for the 128-bit cache mem_req/mem_resp port.
// Byte-masked writes, in-order reads returned after a fixed LATENCY.
module mem_responder #(
    parameter int ADDR_BITS       = 28,
    parameter int DATA_BITS       = 128,
    parameter int DEPTH_LOG2      = 10,
    parameter int LATENCY         = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_req_valid,
    output logic                   mem_req_ready,
    input  logic [ADDR_BITS-1:0]   mem_req_addr,
    input  logic                   mem_req_rw,
    input  logic                   mem_req_data_valid,
    output logic                   mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
    output logic                   mem_resp_valid,
    output logic [DATA_BITS-1:0]   mem_resp_data
);
    localparam int MASK_BITS = DATA_BITS / 8;
    localparam int CNT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam int DEPTH     = 1 << DEPTH_LOG2;

    typedef enum logic {IDLE, WAIT_DATA} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        outstanding;
    logic [DEPTH_LOG2-1:0]   wait_idx;
    logic [DATA_BITS-1:0]    mem [DEPTH];
    logic [LATENCY-1:0]      vld_pipe;
    logic [DATA_BITS-1:0]    data_pipe [LATENCY];

    logic [DEPTH_LOG2-1:0]   req_idx, wr_idx;
    logic addr_hs, data_hs, rd_acc, wr_now, wr_park, wr_late, wr_en, resp_issue;
    // Upper line-address bits alias onto the same storage by design.
    logic unused_addr_hi;

    assign req_idx        = mem_req_addr[DEPTH_LOG2-1:0];
    assign unused_addr_hi = ^mem_req_addr[ADDR_BITS-1:DEPTH_LOG2];

    assign mem_req_ready      = !reset && (state == IDLE) &&
                                (outstanding < CNT_W'(MAX_OUTSTANDING));
    assign mem_req_data_ready = !reset && ((state == IDLE) || (state == WAIT_DATA));

    assign addr_hs    = mem_req_valid && mem_req_ready;
    assign data_hs    = mem_req_data_valid && mem_req_data_ready;
    assign rd_acc     = addr_hs && !mem_req_rw;
    assign wr_now     = addr_hs && mem_req_rw && data_hs;
    assign wr_park    = addr_hs && mem_req_rw && !data_hs;
    assign wr_late    = (state == WAIT_DATA) && data_hs;
    assign wr_en      = wr_now || wr_late;
    assign wr_idx     = wr_late ? wait_idx : req_idx;
    assign resp_issue = vld_pipe[LATENCY-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            outstanding <= '0;
            wait_idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_park) begin
                        state    <= WAIT_DATA;
                        wait_idx <= req_idx;
                    end
                end
                WAIT_DATA: begin
                    if (data_hs)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A read leaves the count in the same cycle its response is presented.
            if (rd_acc && !resp_issue)
                outstanding <= outstanding + CNT_W'(1);
            else if (!rd_acc && resp_issue)
                outstanding <= outstanding - CNT_W'(1);
        end
    end

    // Storage is never reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < MASK_BITS; i++) begin
                if (mem_req_data_mask[i])
                    mem[wr_idx][8*i +: 8] <= mem_req_data_bits[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_acc)
            data_pipe[0] <= mem[req_idx];
        for (int s = 1; s < LATENCY; s++)
            data_pipe[s] <= data_pipe[s-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe       <= '0;
            mem_resp_valid <= 1'b0;
            mem_resp_data  <= '0;
        end else begin
            vld_pipe[0] <= rd_acc;
            for (int s = 1; s < LATENCY; s++)
                vld_pipe[s] <= vld_pipe[s-1];
            mem_resp_valid <= resp_issue;
            if (resp_issue)
                mem_resp_data <= data_pipe[LATENCY-1];
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: queue/array reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_responder;
    localparam int LAT  = 4;
    localparam int MAXO = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [27:0]  mem_req_addr;
    logic         mem_req_rw;
    logic         mem_req_data_valid;
    logic         mem_req_data_ready;
    logic [127:0] mem_req_data_bits;
    logic [15:0]  mem_req_data_mask;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;

    mem_responder dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int due; logic [127:0] data; } rsp_t;
    typedef struct { int cyc; logic [127:0] data; } got_t;
    rsp_t         q[$];
    got_t         got_q[$];
    logic [127:0] mm [int];
    bit           waiting = 0;
    int           widx = 0;
    int           cyc = 0;
    logic [127:0] last = '0;
    bit           live = 0;

    function automatic int n_out();
        int c = 0;
        foreach (q[i]) if (q[i].due > cyc) c++;
        return c;
    endfunction

    function automatic void mwr(input int idx, input logic [127:0] d, input logic [15:0] m);
        logic [127:0] v;
        v = mm.exists(idx) ? mm[idx] : 'x;
        for (int b = 0; b < 16; b++) if (m[b]) v[8*b +: 8] = d[8*b +: 8];
        mm[idx] = v;
    endfunction

    always @(posedge clk) begin
        bit rdy, ah, dh;
        int idx;
        if (reset) begin
            q.delete();
            waiting = 0;
            last    = '0;
            live    = 1;
        end else if (live) begin
            rdy = !waiting && (n_out() < MAXO);
            ah  = mem_req_valid && rdy;
            dh  = mem_req_data_valid;
            idx = int'(mem_req_addr[9:0]);
            if (waiting) begin
                if (dh) begin
                    mwr(widx, mem_req_data_bits, mem_req_data_mask);
                    waiting = 0;
                end
            end else if (ah) begin
                if (!mem_req_rw) q.push_back('{cyc + 1 + LAT, mm[idx]});
                else if (dh) mwr(idx, mem_req_data_bits, mem_req_data_mask);
                else begin
                    waiting = 1;
                    widx    = idx;
                end
            end
        end
        cyc++;
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        if (q.size() > 0 && q[0].due == cyc) last = q[0].data;
    end

    always @(negedge clk) begin
        bit ev;
        if (live) begin
            ev = (q.size() > 0) && (q[0].due == cyc);
            chk("req_ready", {127'b0, mem_req_ready}, {127'b0, !reset && !waiting && (n_out() < MAXO)});
            chk("data_ready", {127'b0, mem_req_data_ready}, {127'b0, !reset});
            chk("resp_valid", {127'b0, mem_resp_valid}, {127'b0, ev});
            chk("resp_data", mem_resp_data, last);
        end
        if (mem_resp_valid === 1'b1) got_q.push_back('{cyc, mem_resp_data});
    end

    // ---------------- stimulus ----------------
    task automatic send(input bit rw, input logic [27:0] a, input logic [127:0] d,
                        input logic [15:0] m, input bit with_data, input int delay,
                        output int tries);
        bit r = 0;
        mem_req_valid      = 1'b1;
        mem_req_rw         = rw;
        mem_req_addr       = a;
        mem_req_data_bits  = d;
        mem_req_data_mask  = m;
        mem_req_data_valid = rw && with_data;
        tries = 0;
        while (!r && tries < 200) begin
            @(negedge clk);
            r = mem_req_ready;
            @(posedge clk); #1;
            tries++;
        end
        mem_req_valid      = 1'b0;
        mem_req_data_valid = 1'b0;
        if (!r) begin
            total++; bad++;
            $display("FAIL accept_timeout addr=%h tries=%0d", a, tries);
        end else if (rw && !with_data) begin
            repeat (delay) begin
                @(negedge clk);
                chk("wait_data_ready", {127'b0, mem_req_ready}, 128'd0);
                @(posedge clk); #1;
            end
            mem_req_data_valid = 1'b1;
            @(posedge clk); #1;
            mem_req_data_valid = 1'b0;
        end
    endtask

    task automatic drain();
        repeat (LAT + 3) @(negedge clk);
        got_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic wait_resps(input int n);
        int k = 0;
        while (got_q.size() < n && k < 40) begin
            @(negedge clk); #1;
            k++;
        end
        if (got_q.size() < n) begin
            total++; bad++;
            $display("FAIL resp_timeout got=%0d want=%0d", got_q.size(), n);
        end
    endtask

    task automatic rd_check(input logic [27:0] a, input logic [127:0] lit, input string nm);
        int t, ac;
        got_t g;
        drain();
        send(1'b0, a, '0, '0, 1'b0, 0, t);
        ac = cyc;
        wait_resps(1);
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            chk(nm, g.data, lit);
            chk({nm, "_latency"}, 128'(g.cyc - ac), 128'd4);
        end
    endtask

    initial begin
        int t, ac0;
        logic [27:0]  a;
        logic [127:0] d;
        logic [15:0]  m;
        got_t g;

        reset = 1'b1;
        mem_req_valid = 0; mem_req_rw = 0; mem_req_addr = '0;
        mem_req_data_valid = 0; mem_req_data_bits = '0; mem_req_data_mask = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_resp_valid", {127'b0, mem_resp_valid}, 128'd0);
        chk("reset_resp_data", mem_resp_data, 128'd0);
        chk("reset_release_ready", {127'b0, mem_req_ready}, 128'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++)
            send(1'b1, 28'(i), {4{32'hA500_0000 | 32'(i)}}, 16'hFFFF, 1'b1, 0, t);

        // full and partial masked writes
        send(1'b1, 28'h000_0005, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'hFFFF, 1'b1, 0, t);
        rd_check(28'h5, 128'h00112233_44556677_8899AABB_CCDDEEFF, "full_write");
        send(1'b1, 28'h5, 128'h00000000_00000000_00000000_DEADBEEF, 16'h000F, 1'b1, 0, t);
        rd_check(28'h5, 128'h00112233_44556677_8899AABB_DEADBEEF, "partial_write");
        send(1'b1, 28'h5, 128'h55555555_55555555_55555555_55555555, 16'h0000, 1'b1, 0, t);
        rd_check(28'h5, 128'h00112233_44556677_8899AABB_DEADBEEF, "zero_mask");

        // decoupled data beat
        send(1'b1, 28'h7, 128'd0, 16'hFFFF, 1'b1, 0, t);
        send(1'b1, 28'h7, 128'hCAFEF00D_01234567_89ABCDEF_76543210, 16'hF000, 1'b0, 3, t);
        @(negedge clk);
        chk("ready_after_data", {127'b0, mem_req_ready}, 128'd1);
        @(posedge clk); #1;
        rd_check(28'h7, 128'hCAFEF00D_00000000_00000000_00000000, "decoupled");

        // pipelined reads and the stall of a 5th
        drain();
        send(1'b0, 28'h0, '0, '0, 1'b0, 0, t);
        ac0 = cyc;
        for (int i = 1; i < 4; i++) send(1'b0, 28'(i), '0, '0, 1'b0, 0, t);
        send(1'b0, 28'h4, '0, '0, 1'b0, 0, t);
        chk("fifth_read_tries", 128'(t), 128'd2);
        wait_resps(5);
        for (int i = 0; i < 5 && got_q.size() > 0; i++) begin
            g = got_q.pop_front();
            chk("pipe_data", g.data, {4{32'hA500_0000 | 32'(i)}});
            chk("pipe_cycle", 128'(g.cyc - ac0), 128'(i < 4 ? 4 + i : 9));
        end

        // in-flight snapshot vs later write
        send(1'b1, 28'h9, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 16'hFFFF, 1'b1, 0, t);
        drain();
        send(1'b0, 28'h9, '0, '0, 1'b0, 0, t);
        send(1'b1, 28'h9, {128{1'b1}}, 16'hFFFF, 1'b1, 0, t);
        send(1'b0, 28'h9, '0, '0, 1'b0, 0, t);
        wait_resps(2);
        if (got_q.size() >= 2) begin
            g = got_q.pop_front();
            chk("snapshot_old", g.data, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
            g = got_q.pop_front();
            chk("snapshot_new", g.data, {128{1'b1}});
        end

        // reset with reads in flight and FSM parked in WAIT_DATA
        drain();
        send(1'b0, 28'h1, '0, '0, 1'b0, 0, t);
        send(1'b0, 28'h2, '0, '0, 1'b0, 0, t);
        mem_req_valid = 1'b1; mem_req_rw = 1'b1; mem_req_addr = 28'hB;
        @(posedge clk); #1;
        mem_req_valid = 1'b0;
        reset = 1'b1;
        got_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", {127'b0, mem_req_ready}, 128'd1);
        repeat (10) @(negedge clk);
        chk("post_reset_no_resp", 128'(got_q.size()), 128'd0);
        @(posedge clk); #1;
        rd_check(28'h5, 128'h00112233_44556677_8899AABB_DEADBEEF, "preserved_line");

        // randomized traffic with aliased upper address bits
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 99);
            a = 28'($urandom);
            a[9:4] = 6'd0;
            d = {$urandom, $urandom, $urandom, $urandom};
            m = 16'($urandom);
            if ($urandom_range(0, 7) == 0) m = 16'h0000;
            else if ($urandom_range(0, 7) == 0) m = 16'hFFFF;
            if (r < 50) send(1'b0, a, d, m, 1'b0, 0, t);
            else if (r < 75) send(1'b1, a, d, m, 1'b1, 0, t);
            else if (r < 88) send(1'b1, a, d, m, 1'b0, int'($urandom_range(0, 3)), t);
            else begin
                mem_req_data_valid = 1'b1;
                mem_req_data_bits  = d;
                mem_req_data_mask  = m;
                @(posedge clk); #1;
                mem_req_data_valid = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
